// File: rtl/reversi_pkg.sv
// Shared reversi definitions: cell codes, direction/state enums, coordinates
// and the flat board cell-index helper.
package reversi_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  localparam logic [2:0] MAX_STEPS = 3'd6;

  typedef logic [2:0] coord_t;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PLACE, S_SEL, S_WALK, S_DONE
  } state_t;

  // Row-major cell number 8y+x.
  function automatic logic [5:0] cell_idx(input coord_t cx, input coord_t cy);
    return {cy, cx};
  endfunction

endpackage

// File: rtl/reversi_step.sv
// One-cell neighbour computation in a given direction, flagging moves that
// leave the 8x8 board.
module reversi_step
  import reversi_pkg::*;
(
  input  coord_t x,
  input  coord_t y,
  input  dir_t   dir,
  output coord_t nx,
  output coord_t ny,
  output logic   off_board
);

  logic [3:0] xs;
  logic [3:0] ys;

  // One extra bit catches both -1 (4'hF) and 8 as off-board.
  always_comb begin
    xs = {1'b0, x};
    ys = {1'b0, y};
    case (dir)
      DIR_N:  begin                        ys = {1'b0, y} - 4'd1; end
      DIR_NE: begin xs = {1'b0, x} + 4'd1; ys = {1'b0, y} - 4'd1; end
      DIR_E:  begin xs = {1'b0, x} + 4'd1;                        end
      DIR_SE: begin xs = {1'b0, x} + 4'd1; ys = {1'b0, y} + 4'd1; end
      DIR_S:  begin                        ys = {1'b0, y} + 4'd1; end
      DIR_SW: begin xs = {1'b0, x} - 4'd1; ys = {1'b0, y} + 4'd1; end
      DIR_W:  begin xs = {1'b0, x} - 4'd1;                        end
      DIR_NW: begin xs = {1'b0, x} - 4'd1; ys = {1'b0, y} - 4'd1; end
      default: begin xs = {1'b0, x}; ys = {1'b0, y}; end
    endcase
  end

  assign nx        = xs[2:0];
  assign ny        = ys[2:0];
  assign off_board = xs[3] | ys[3];

endmodule

// File: rtl/flip_discs.sv
// Move-commit stage: places the mover's disc, then walks each flagged
// direction one cell per clock flipping discs up to that direction's end point.
module flip_discs
  import reversi_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   x,
  input  logic [2:0]   y,
  input  logic         player_black,
  input  logic [7:0]   valid,
  input  logic [47:0]  end_points,
  input  logic [127:0] board_in,
  output logic [127:0] board_out,
  output logic         busy,
  output logic         done,
  output logic         illegal,
  output logic         err,
  output logic [4:0]   flip_count
);

  state_t      state_reg;
  coord_t      x_reg, y_reg;
  coord_t      cur_x_reg, cur_y_reg;
  logic [1:0]  code_reg;
  logic [7:0]  mask_reg;
  logic [47:0] end_reg;
  dir_t        dir_reg;
  logic [2:0]  step_reg;

  logic [5:0]  ep_arr [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ep
      assign ep_arr[gi] = end_reg[6*gi +: 6];
    end
  endgenerate

  // Lowest-numbered remaining direction wins.
  dir_t sel_dir;
  logic sel_any;
  always_comb begin
    sel_dir = DIR_N;
    sel_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_reg[i]) begin
        sel_dir = dir_t'(i[2:0]);
        sel_any = 1'b1;
      end
    end
  end

  coord_t nx, ny;
  logic   off_board;

  reversi_step u_step (
    .x         (cur_x_reg),
    .y         (cur_y_reg),
    .dir       (dir_reg),
    .nx        (nx),
    .ny        (ny),
    .off_board (off_board)
  );

  // A wrapped off-board coordinate must never be mistaken for the end point.
  logic at_end;
  assign at_end = !off_board && ({nx, ny} == ep_arr[dir_reg]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      board_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      err        <= 1'b0;
      flip_count <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      cur_x_reg  <= '0;
      cur_y_reg  <= '0;
      code_reg   <= CELL_BLACK;
      mask_reg   <= '0;
      end_reg    <= '0;
      dir_reg    <= DIR_N;
      step_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x_reg      <= x;
            y_reg      <= y;
            code_reg   <= player_black ? CELL_BLACK : CELL_WHITE;
            mask_reg   <= valid;
            end_reg    <= end_points;
            board_out  <= board_in;
            flip_count <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            illegal    <= (valid == 8'd0);
            if (valid == 8'd0) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_PLACE;
            end
          end
        end
        S_PLACE: begin
          board_out[{cell_idx(x_reg, y_reg), 1'b0} +: 2] <= code_reg;
          state_reg <= S_SEL;
        end
        S_SEL: begin
          if (sel_any) begin
            mask_reg  <= mask_reg & ~(8'd1 << sel_dir);
            dir_reg   <= sel_dir;
            cur_x_reg <= x_reg;
            cur_y_reg <= y_reg;
            step_reg  <= '0;
            state_reg <= S_WALK;
          end else begin
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_WALK: begin
          if (at_end) begin
            state_reg <= S_SEL;
          end else if (off_board || step_reg == MAX_STEPS) begin
            err       <= 1'b1;
            state_reg <= S_SEL;
          end else begin
            board_out[{cell_idx(nx, ny), 1'b0} +: 2] <= code_reg;
            cur_x_reg  <= nx;
            cur_y_reg  <= ny;
            flip_count <= flip_count + 5'd1;
            step_reg   <= step_reg + 3'd1;
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flip_discs.sv
// Scoreboard bench for flip_discs: a driver pushes reference-model results,
// a monitor pops and compares them on every done pulse.
module tb_flip_discs;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   x = '0, y = '0;
  logic         player_black = 1'b0;
  logic [7:0]   valid = '0;
  logic [47:0]  end_points = '0;
  logic [127:0] board_in = '0;
  logic [127:0] board_out;
  logic         busy, done, illegal, err;
  logic [4:0]   flip_count;

  flip_discs dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .player_black(player_black), .valid(valid), .end_points(end_points),
    .board_in(board_in), .board_out(board_out), .busy(busy), .done(done),
    .illegal(illegal), .err(err), .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] board;
    int           flips;
    bit           ill;
    bit           er;
    int           lat;
    int           e0;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int dx_of(input int d);
    case (d)
      1, 2, 3: return 1;
      5, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy_of(input int d);
    case (d)
      0, 1, 7: return -1;
      3, 4, 5: return 1;
      default: return 0;
    endcase
  endfunction

  // Reference: place disc, then for each flagged direction in ascending order
  // paint cells until the end point, an off-board cell or the 6-flip limit.
  function automatic exp_t model(input logic [127:0] b, input int px, input int py,
                                 input bit pb, input logic [7:0] v, input logic [47:0] ep);
    exp_t m;
    logic [1:0] code;
    int ex, ey, cx, cy, nx, ny, n;
    m.board = b; m.flips = 0; m.ill = (v == 8'd0); m.er = 0; m.lat = 1; m.e0 = 0;
    if (v != 8'd0) begin
      code = pb ? 2'b01 : 2'b10;
      m.board[(py*8+px)*2 +: 2] = code;
      m.lat = 3;
      for (int d = 0; d < 8; d++) begin
        if (v[d]) begin
          ex = int'(ep[6*d+3 +: 3]);
          ey = int'(ep[6*d +: 3]);
          cx = px; cy = py; n = 0;
          for (int s = 0; s <= 6; s++) begin
            nx = cx + dx_of(d);
            ny = cy + dy_of(d);
            if (nx == ex && ny == ey) break;
            if (nx < 0 || nx > 7 || ny < 0 || ny > 7 || n == 6) begin
              m.er = 1;
              break;
            end
            m.board[(ny*8+nx)*2 +: 2] = code;
            cx = nx; cy = ny; n++; m.flips++;
          end
          m.lat += n + 2;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [47:0] set_ep(input logic [47:0] ep, input int d, input int ex, input int ey);
    logic [47:0] r;
    logic [2:0] ux, uy;
    r = ep;
    ux = ex[2:0];
    uy = ey[2:0];
    r[6*d +: 6] = {ux, uy};
    return r;
  endfunction

  function automatic logic [127:0] set_cell(input logic [127:0] b, input int cx, input int cy, input logic [1:0] c);
    logic [127:0] r;
    r = b;
    r[(cy*8+cx)*2 +: 2] = c;
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      chk("done_timeout", 1, 0);
      q.delete();
    end
  endtask

  task automatic issue(input logic [127:0] b, input int px, input int py, input bit pb,
                       input logic [7:0] v, input logic [47:0] ep,
                       input bit use_manual, input exp_t manual, input bit pulse_busy);
    exp_t e;
    wait_idle();
    board_in = b; x = px[2:0]; y = py[2:0]; player_black = pb; valid = v; end_points = ep;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = use_manual ? manual : model(b, px, py, pb, v, ep);
    e.e0 = cyc;
    q.push_back(e);
    x = 3'($urandom); y = 3'($urandom); valid = 8'($urandom); end_points = {$urandom, 16'($urandom)};
    board_in = {$urandom, $urandom, $urandom, $urandom};
    if (pulse_busy) begin
      @(negedge clk);
      @(negedge clk); start = 1'b1; valid = 8'hFF;
      @(negedge clk); start = 1'b0;
    end
    wait_drain();
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("board_out", board_out, e.board);
          chk("flip_count", 128'(flip_count), 128'(e.flips));
          chk("illegal", 128'(illegal), 128'(e.ill));
          chk("err", 128'(err), 128'(e.er));
          chk("done_cycle", 128'(cyc - e.e0 + 1), 128'(e.lat));
          chk("busy_at_done", 128'(busy), 128'd1);
          $display("move: flips=%0d ill=%0d err=%0d lat=%0d", flip_count, illegal, err, cyc - e.e0 + 1);
          @(negedge clk);
          chk("busy_after_done", 128'(busy), 128'd0);
          chk("done_one_cycle", 128'(done), 128'd0);
          chk("board_hold", board_out, e.board);
        end
      end
    end
  end

  initial begin
    logic [127:0] b, opening;
    logic [47:0]  ep;
    logic [7:0]   v;
    exp_t man, none;
    int px, py, k, ex, ey;

    none = '{board: '0, flips: 0, ill: 0, er: 0, lat: 0, e0: 0};

    repeat (3) @(negedge clk);
    chk("rst_board", board_out, '0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_flips", 128'(flip_count), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Opening position, black plays (2,3) capturing east.
    opening = '0;
    opening = set_cell(opening, 3, 3, 2'b10);
    opening = set_cell(opening, 4, 4, 2'b10);
    opening = set_cell(opening, 3, 4, 2'b01);
    opening = set_cell(opening, 4, 3, 2'b01);
    man = none;
    man.board = set_cell(set_cell(opening, 2, 3, 2'b01), 3, 3, 2'b01);
    man.flips = 1; man.lat = 6;
    issue(opening, 2, 3, 1'b1, 8'h04, set_ep('0, 2, 4, 3), 1'b1, man, 1'b0);

    // Illegal: valid == 0.
    man = none;
    man.board = opening; man.ill = 1; man.lat = 1;
    issue(opening, 5, 5, 1'b0, 8'h00, '0, 1'b1, man, 1'b0);

    // N (k=2) and S (k=1) from (3,4): done in cycle 10.
    ep = set_ep(set_ep('0, 0, 3, 1), 4, 3, 6);
    man = model(opening, 3, 4, 1'b0, 8'h11, ep);
    man.lat = 10; man.flips = 3;
    issue(opening, 3, 4, 1'b0, 8'h11, ep, 1'b1, man, 1'b0);

    // Corrupt W end point from (1,0) plus a normal E direction.
    ep = set_ep(set_ep('0, 6, 7, 0), 2, 4, 0);
    issue(opening, 1, 0, 1'b1, 8'h44, ep, 1'b0, none, 1'b0);

    // Reset in the middle of a walk.
    wait_idle();
    board_in = opening; x = 3'd3; y = 3'd7; player_black = 1'b1;
    valid = 8'h01; end_points = set_ep('0, 0, 3, 2);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midwalk_rst_board", board_out, '0);
    chk("midwalk_rst_busy", 128'(busy), 128'd0);
    chk("midwalk_rst_flips", 128'(flip_count), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(opening, 2, 3, 1'b1, 8'h04, set_ep('0, 2, 4, 3), 1'b0, none, 1'b0);

    // Start pulsed while busy must be ignored.
    ep = set_ep(set_ep('0, 0, 3, 1), 4, 3, 6);
    issue(opening, 3, 4, 1'b1, 8'h11, ep, 1'b0, none, 1'b1);

    // Randomized moves; end points mostly at a chosen distance, sometimes corrupt.
    for (int t = 0; t < 40; t++) begin
      b = '0;
      for (int c = 0; c < 64; c++) b[c*2 +: 2] = 2'($urandom_range(0, 2));
      px = $urandom_range(0, 7);
      py = $urandom_range(0, 7);
      v = (t % 9 == 0) ? 8'h00 : 8'($urandom);
      ep = {$urandom, 16'($urandom)};
      for (int d = 0; d < 8; d++) begin
        k = $urandom_range(0, 6);
        ex = px + (k + 1) * dx_of(d);
        ey = py + (k + 1) * dy_of(d);
        if (ex >= 0 && ex <= 7 && ey >= 0 && ey <= 7 && $urandom_range(0, 3) != 0)
          ep = set_ep(ep, d, ex, ey);
      end
      issue(b, px, py, 1'($urandom), v, ep, 1'b0, none, (v != 8'h00) && (t % 5 == 1));
    end

    wait_drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
